// File: rtl/io_led_seq_if.sv
// IO store bus into the LED sequencer window: byte enables, word address, data.
interface io_led_seq_if;
  logic [3:0]  st_we_io;
  logic [9:0]  st_adr_io;
  logic [31:0] st_data_io;

  modport master (output st_we_io, st_adr_io, st_data_io);
  modport slave  (input  st_we_io, st_adr_io, st_data_io);
endinterface

// File: rtl/io_led_seq.sv
// RGB LED sequencer: static colour or 4-step pattern (one-shot/looped) with PWM dimming.
//
//   state  | meaning
//   S_IDLE | colour comes from LED register
//   S_RUN  | colour comes from PAT[idx], stepping every STEP_LEN cycles
module io_led_seq #(
  parameter int PWM_BITS  = 8,
  parameter int STEP_BITS = 24
) (
  input  logic        clk,
  input  logic        rst,
  io_led_seq_if.slave bus,
  output logic [2:0]  rgb_led,
  output logic        seq_busy,
  output logic        seq_done
);
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [2:0]           led_q, led_d;
  logic [2:0]           ctrl_q, ctrl_d;   // {pwm_en, loop, seq_en}
  logic [STEP_BITS-1:0] step_len_q, step_len_d;
  logic [STEP_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0]  duty_q, duty_d;
  logic [PWM_BITS-1:0]  pwm_cnt_q;
  logic [2:0]           pat_q [4];
  logic [2:0]           pat_d [4];
  logic [1:0]           idx_q, idx_d;
  logic [2:0]           rgb_q, rgb_d;
  logic                 done_q, done_d;

  logic                 wr, wr_led, wr_ctrl, wr_step, wr_duty, wr_pat;
  logic [STEP_BITS-1:0] step_last;
  logic                 step_end;
  logic [2:0]           colour;
  logic                 unused_bus;

  assign wr      = bus.st_we_io[0];
  assign wr_led  = wr && (bus.st_adr_io == 10'd0);
  assign wr_ctrl = wr && (bus.st_adr_io == 10'd1);
  assign wr_step = wr && (bus.st_adr_io == 10'd2);
  assign wr_duty = wr && (bus.st_adr_io == 10'd3);
  assign wr_pat  = wr && (bus.st_adr_io[9:2] == 8'd1);

  assign unused_bus = ^{bus.st_we_io[3:1], bus.st_data_io};

  // A step length of zero behaves as one cycle per step.
  assign step_last = (step_len_q == '0) ? '0 : step_len_q - STEP_BITS'(1);
  assign step_end  = (cnt_q >= step_last);

  always_comb begin
    state_d    = state_q;
    led_d      = led_q;
    ctrl_d     = ctrl_q;
    step_len_d = step_len_q;
    duty_d     = duty_q;
    pat_d      = pat_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    colour     = 3'b000;

    if (wr_led)  led_d      = bus.st_data_io[2:0];
    if (wr_ctrl) ctrl_d     = bus.st_data_io[2:0];
    if (wr_step) step_len_d = bus.st_data_io[STEP_BITS-1:0];
    if (wr_duty) duty_d     = bus.st_data_io[PWM_BITS-1:0];
    if (wr_pat)  pat_d[bus.st_adr_io[1:0]] = bus.st_data_io[2:0];

    case (state_q)
      S_IDLE: begin
        if (wr_ctrl && bus.st_data_io[0]) begin
          state_d = S_RUN;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        // A CTRL write overrides whatever the step counter would have done.
        if (wr_ctrl) begin
          state_d = bus.st_data_io[0] ? S_RUN : S_IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else if (step_end) begin
          cnt_d = '0;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3 && !ctrl_q[1]) begin
            state_d   = S_IDLE;
            ctrl_d[0] = 1'b0;
            done_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + STEP_BITS'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    colour = (state_q == S_RUN) ? pat_q[idx_q] : led_q;
    if (ctrl_q[2] && !(pwm_cnt_q < duty_q)) colour = 3'b000;
    rgb_d = colour;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      led_q      <= '0;
      ctrl_q     <= '0;
      step_len_q <= '0;
      duty_q     <= '0;
      pat_q      <= '{default: '0};
      idx_q      <= '0;
      cnt_q      <= '0;
      pwm_cnt_q  <= '0;
      rgb_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      ctrl_q     <= ctrl_d;
      step_len_q <= step_len_d;
      duty_q     <= duty_d;
      pat_q      <= pat_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pwm_cnt_q  <= pwm_cnt_q + PWM_BITS'(1);
      rgb_q      <= rgb_d;
      done_q     <= done_d;
    end
  end

  assign rgb_led  = rgb_q;
  assign seq_busy = (state_q == S_RUN);
  assign seq_done = done_q;
endmodule

// File: tb/tb_io_led_seq.sv
// Directed plus randomized bench for io_led_seq against an edge-indexed reference model.
module tb_io_led_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rgb_led;
  logic       seq_busy;
  logic       seq_done;

  io_led_seq_if bus();

  io_led_seq #(.PWM_BITS(8), .STEP_BITS(24)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rgb_led  (rgb_led),
    .seq_busy (seq_busy),
    .seq_done (seq_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: time is the edge number; steps are measured in edges since the step began.
  int   e = 0;
  int   rst_edge = 0;
  int   start_edge = 0;
  int   m_led, m_step_len, m_duty, m_idx;
  bit   m_loop, m_pwm_en, m_run;
  int   m_pat [4];
  logic [2:0] exp_rgb;
  logic exp_busy, exp_done;
  int   busy_cnt, done_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_edge(input logic r, input logic [3:0] we, input logic [9:0] adr,
                            input logic [31:0] data);
    int leff;
    int src;
    bit on;
    e++;
    if (r) begin
      m_led = 0; m_step_len = 0; m_duty = 0; m_idx = 0;
      m_loop = 0; m_pwm_en = 0; m_run = 0;
      for (int i = 0; i < 4; i++) m_pat[i] = 0;
      rst_edge = e;
      exp_rgb = 3'b000; exp_busy = 1'b0; exp_done = 1'b0;
      return;
    end
    src = m_run ? m_pat[m_idx] : m_led;
    on  = !m_pwm_en || ((((e - 1) - rst_edge) % 256) < m_duty);
    exp_rgb  = on ? 3'(src) : 3'b000;
    exp_done = 1'b0;
    leff = (m_step_len == 0) ? 1 : m_step_len;
    if (we[0] && adr == 10'd1) begin
      m_run = data[0];
      m_idx = 0;
      start_edge = e;
    end else if (m_run && (e - start_edge) >= leff) begin
      start_edge = e;
      if (m_idx == 3) begin
        m_idx = 0;
        if (!m_loop) begin
          m_run = 0;
          exp_done = 1'b1;
        end
      end else begin
        m_idx++;
      end
    end
    if (we[0]) begin
      case (adr)
        10'd0: m_led = int'(data[2:0]);
        10'd1: begin m_loop = data[1]; m_pwm_en = data[2]; end
        10'd2: m_step_len = int'(data[23:0]);
        10'd3: m_duty = int'(data[7:0]);
        10'd4, 10'd5, 10'd6, 10'd7: m_pat[int'(adr) - 4] = int'(data[2:0]);
        default: ;
      endcase
    end
    exp_busy = m_run;
  endtask

  task automatic cyc(input logic [3:0] we, input logic [9:0] adr, input logic [31:0] data,
                     input logic r);
    bus.st_we_io   = we;
    bus.st_adr_io  = adr;
    bus.st_data_io = data;
    rst            = r;
    @(posedge clk);
    model_edge(r, we, adr, data);
    @(negedge clk);
    check("rgb_led", 32'(rgb_led), 32'(exp_rgb));
    check("seq_busy", 32'(seq_busy), 32'(exp_busy));
    check("seq_done", 32'(seq_done), 32'(exp_done));
    busy_cnt += int'(seq_busy);
    done_cnt += int'(seq_done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'h0, 10'd0, 32'd0, 1'b0);
  endtask

  task automatic wr(input logic [9:0] adr, input logic [31:0] data);
    cyc(4'h1, adr, data, 1'b0);
  endtask

  initial begin
    int oneshot_seq [12];
    int loop_seq [8];
    int on_cnt;
    int r;
    logic [9:0]  a;
    logic [31:0] d;
    oneshot_seq = '{1, 1, 1, 2, 2, 2, 4, 4, 4, 7, 7, 7};
    loop_seq    = '{1, 2, 4, 7, 1, 2, 4, 7};
    busy_cnt = 0;
    done_cnt = 0;
    bus.st_we_io = 4'h0; bus.st_adr_io = 10'd0; bus.st_data_io = 32'd0;

    cyc(4'h0, 10'd0, 32'd0, 1'b1);
    cyc(4'h0, 10'd0, 32'd0, 1'b1);
    check("reset_rgb", 32'(rgb_led), 32'd0);

    // Static colour, then a store without byte 0 enabled.
    wr(10'd0, 32'h5);
    idle(1);
    check("static_led", 32'(rgb_led), 32'h5);
    cyc(4'h2, 10'd0, 32'h2, 1'b0);
    idle(1);
    check("we_no_byte0", 32'(rgb_led), 32'h5);

    // One-shot sequence.
    wr(10'd4, 32'd1); wr(10'd5, 32'd2); wr(10'd6, 32'd4); wr(10'd7, 32'd7);
    wr(10'd2, 32'd3);
    busy_cnt = 0; done_cnt = 0;
    wr(10'd1, 32'h1);
    for (int i = 0; i < 12; i++) begin
      idle(1);
      check("oneshot_seq", 32'(rgb_led), 32'(oneshot_seq[i]));
    end
    idle(1);
    check("oneshot_led", 32'(rgb_led), 32'h5);
    idle(3);
    check("oneshot_busy_len", 32'(busy_cnt), 32'd12);
    check("oneshot_done_cnt", 32'(done_cnt), 32'd1);

    // Loop with STEP_LEN=0, then abort.
    wr(10'd2, 32'd0);
    done_cnt = 0;
    wr(10'd1, 32'h3);
    for (int i = 0; i < 8; i++) begin
      idle(1);
      check("loop_seq", 32'(rgb_led), 32'(loop_seq[i]));
    end
    wr(10'd1, 32'h0);
    check("abort_busy", 32'(seq_busy), 32'd0);
    idle(3);
    check("abort_no_done", 32'(done_cnt), 32'd0);

    // PWM dimming.
    wr(10'd0, 32'h7);
    wr(10'd3, 32'd64);
    wr(10'd1, 32'h4);
    idle(2);
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      idle(1);
      if (rgb_led == 3'h7) on_cnt++;
    end
    check("pwm_duty64", 32'(on_cnt), 32'd64);
    wr(10'd3, 32'd0);
    idle(2);
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      idle(1);
      if (rgb_led != 3'h0) on_cnt++;
    end
    check("pwm_duty0", 32'(on_cnt), 32'd0);
    wr(10'd1, 32'h0);

    // CTRL restart colliding with the final step end.
    wr(10'd2, 32'd3);
    wr(10'd1, 32'h1);
    idle(11);
    done_cnt = 0;
    wr(10'd1, 32'h1);
    idle(1);
    check("collide_pat0", 32'(rgb_led), 32'd1);
    check("collide_no_done", 32'(done_cnt), 32'd0);
    check("collide_busy", 32'(seq_busy), 32'd1);
    idle(14);

    // STEP_LEN shortened below the running count.
    wr(10'd2, 32'd10);
    wr(10'd1, 32'h1);
    idle(5);
    wr(10'd2, 32'd2);
    idle(1);
    check("steplen_pat0", 32'(rgb_led), 32'd1);
    idle(1);
    check("steplen_pat1", 32'(rgb_led), 32'd2);

    // Reset mid-run.
    wr(10'd1, 32'h3);
    idle(5);
    cyc(4'h0, 10'd0, 32'd0, 1'b1);
    check("midrst_rgb", 32'(rgb_led), 32'd0);
    check("midrst_busy", 32'(seq_busy), 32'd0);
    wr(10'd0, 32'h6);
    idle(1);
    check("post_rst_led", 32'(rgb_led), 32'h6);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        cyc(4'h0, 10'd0, 32'd0, 1'b1);
      end else if (r < 30) begin
        a = 10'($urandom_range(0, 9));
        if ($urandom_range(0, 9) == 0) a = 10'($urandom_range(0, 1023));
        d = $urandom;
        if (a == 10'd2) d = (d & 32'hFF00_0000) | 32'($urandom_range(0, 4));
        cyc(4'($urandom_range(0, 15)), a, d, 1'b0);
      end else begin
        idle(1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
